// File: rtl/spi_controller.sv
// SPI Mode 0 initiator with a byte-wide valid/ready front end; tx_last_i frames CS_N.
// Define SPI_CONTROLLER_LOOPBACK_EN to add loopback_i, which feeds MOSI back into the receiver.

module spi_controller #(
   parameter int unsigned SCK_HALF_PERIOD = 4,
   parameter int unsigned CS_GAP          = 4
) (
   input  logic       clk_sys_i,
   input  logic       reset_ni,
   input  logic [7:0] tx_byte_i,
   input  logic       tx_last_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       busy_o,
   output logic       spi_cs_no,
   output logic       spi_sck_o,
   output logic       spi_tx_o,
`ifdef SPI_CONTROLLER_LOOPBACK_EN
   input  logic       loopback_i,
`endif
   input  logic       spi_rx_i
);

   if (SCK_HALF_PERIOD < 2) begin : g_bad_half_period
      $fatal(1, "SCK_HALF_PERIOD must be at least 2");
   end
   if (CS_GAP < 1) begin : g_bad_cs_gap
      $fatal(1, "CS_GAP must be at least 1");
   end
   if (2 * SCK_HALF_PERIOD > 65536 || CS_GAP > 65536) begin : g_bad_range
      $fatal(1, "SCK_HALF_PERIOD or CS_GAP too large for the 16-bit counter");
   end

   localparam logic [15:0] HalfLoad = 16'(SCK_HALF_PERIOD - 1);
   // HOLD spans the trailing SCK-low half of the last bit plus one half-period of CS_N hold.
   localparam logic [15:0] HoldLoad = 16'(2 * SCK_HALF_PERIOD - 1);
   localparam logic [15:0] GapLoad  = 16'(CS_GAP - 1);

   typedef enum logic [2:0] {StIdle, StLow, StHigh, StNext, StHold, StGap} state_e;

   state_e      state;
   logic [15:0] cnt;
   logic [2:0]  bit_count;
   logic [7:0]  tx_shift;
   logic [7:0]  rx_shift;
   logic [1:0]  rx_sync;
   logic        last_q;
   logic        rx_in;

`ifdef SPI_CONTROLLER_LOOPBACK_EN
   logic loopback_q;

   always_ff @(posedge clk_sys_i or negedge reset_ni) begin
      if (!reset_ni) begin
         loopback_q <= 1'b0;
      end else if (state == StIdle) begin
         loopback_q <= loopback_i;
      end
   end

   assign rx_in = loopback_q ? spi_tx_o : spi_rx_i;
`else
   assign rx_in = spi_rx_i;
`endif

   always_ff @(posedge clk_sys_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state      <= StGap;
         cnt        <= GapLoad;
         bit_count  <= 3'd0;
         tx_shift   <= 8'h00;
         rx_shift   <= 8'h00;
         rx_sync    <= 2'b00;
         last_q     <= 1'b0;
         spi_cs_no  <= 1'b1;
         spi_sck_o  <= 1'b0;
         spi_tx_o   <= 1'b0;
         tx_ready_o <= 1'b0;
         rx_valid_o <= 1'b0;
         rx_byte_o  <= 8'h00;
         busy_o     <= 1'b0;
      end else begin
         rx_sync    <= {rx_sync[0], rx_in};
         rx_valid_o <= 1'b0;
         unique case (state)
            StIdle, StNext: begin
               if (tx_valid_i && tx_ready_o) begin
                  tx_shift   <= tx_byte_i;
                  last_q     <= tx_last_i;
                  spi_tx_o   <= tx_byte_i[7];
                  bit_count  <= 3'd0;
                  spi_cs_no  <= 1'b0;
                  tx_ready_o <= 1'b0;
                  busy_o     <= 1'b1;
                  cnt        <= HalfLoad;
                  state      <= StLow;
               end
            end
            StLow: begin
               if (cnt == 16'd0) begin
                  spi_sck_o <= 1'b1;
                  cnt       <= HalfLoad;
                  state     <= StHigh;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            StHigh: begin
               if (cnt == 16'd0) begin
                  spi_sck_o <= 1'b0;
                  // rx_sync[1] is MISO as it stood two cycles ago, already settled after the
                  // previous falling edge.
                  rx_shift  <= {rx_shift[6:0], rx_sync[1]};
                  if (bit_count != 3'd7) begin
                     spi_tx_o  <= tx_shift[6];
                     tx_shift  <= {tx_shift[6:0], 1'b0};
                     bit_count <= bit_count + 3'd1;
                     cnt       <= HalfLoad;
                     state     <= StLow;
                  end else begin
                     rx_byte_o  <= {rx_shift[6:0], rx_sync[1]};
                     rx_valid_o <= 1'b1;
                     if (last_q) begin
                        cnt   <= HoldLoad;
                        state <= StHold;
                     end else begin
                        tx_ready_o <= 1'b1;
                        state      <= StNext;
                     end
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            StHold: begin
               if (cnt == 16'd0) begin
                  spi_cs_no <= 1'b1;
                  cnt       <= GapLoad;
                  state     <= StGap;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            StGap: begin
               if (cnt == 16'd0) begin
                  tx_ready_o <= 1'b1;
                  busy_o     <= 1'b0;
                  state      <= StIdle;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               spi_cs_no  <= 1'b1;
               spi_sck_o  <= 1'b0;
               tx_ready_o <= 1'b0;
               cnt        <= GapLoad;
               state      <= StGap;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a 4-cycle half-period instance with a Mode 0 peripheral
// model, and a 2-cycle half-period instance whose peripheral answers one cycle late.

module tb_spi_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [7:0] a_byte, a_rx_byte;
   logic       a_last, a_valid, a_ready, a_rx_valid, a_busy, a_cs, a_sck, a_mosi, a_miso;
   logic [7:0] b_byte, b_rx_byte;
   logic       b_last, b_valid, b_ready, b_rx_valid, b_busy, b_cs, b_sck, b_mosi, b_miso;
`ifdef SPI_CONTROLLER_LOOPBACK_EN
   logic       a_loop;
   logic       b_loop;
`endif

   int checks   = 0;
   int failures = 0;

   spi_controller #(.SCK_HALF_PERIOD(4), .CS_GAP(4)) u_dut_a (
      .clk_sys_i (clk),
      .reset_ni  (rst_n),
      .tx_byte_i (a_byte),
      .tx_last_i (a_last),
      .tx_valid_i(a_valid),
      .tx_ready_o(a_ready),
      .rx_byte_o (a_rx_byte),
      .rx_valid_o(a_rx_valid),
      .busy_o    (a_busy),
      .spi_cs_no (a_cs),
      .spi_sck_o (a_sck),
      .spi_tx_o  (a_mosi),
`ifdef SPI_CONTROLLER_LOOPBACK_EN
      .loopback_i(a_loop),
`endif
      .spi_rx_i  (a_miso)
   );

   spi_controller #(.SCK_HALF_PERIOD(2), .CS_GAP(4)) u_dut_b (
      .clk_sys_i (clk),
      .reset_ni  (rst_n),
      .tx_byte_i (b_byte),
      .tx_last_i (b_last),
      .tx_valid_i(b_valid),
      .tx_ready_o(b_ready),
      .rx_byte_o (b_rx_byte),
      .rx_valid_o(b_rx_valid),
      .busy_o    (b_busy),
      .spi_cs_no (b_cs),
      .spi_sck_o (b_sck),
      .spi_tx_o  (b_mosi),
`ifdef SPI_CONTROLLER_LOOPBACK_EN
      .loopback_i(b_loop),
`endif
      .spi_rx_i  (b_miso)
   );

   // Peripheral A: presents byte MSB at CS_N fall, shifts on each SCK fall.
   logic [7:0] miso_mem [32];
   int         am_wr = 0;
   int         am_rd = 0;
   logic [7:0] pa_sh = 8'h00;
   int         pa_bits = 0;
   logic       pa_cs_seen;
   bit         force_one = 1'b0;

   always @(a_cs or negedge a_sck) begin
      if (a_cs !== pa_cs_seen) begin
         pa_cs_seen = a_cs;
         if (a_cs === 1'b0) begin
            pa_bits = 0;
            pa_sh = (am_rd < am_wr) ? miso_mem[am_rd] : 8'h00;
            if (am_rd < am_wr) am_rd++;
         end
      end else if (a_cs === 1'b0 && a_sck === 1'b0) begin
         pa_bits++;
         if (pa_bits == 8) begin
            pa_bits = 0;
            pa_sh = (am_rd < am_wr) ? miso_mem[am_rd] : 8'h00;
            if (am_rd < am_wr) am_rd++;
         end else begin
            pa_sh = {pa_sh[6:0], 1'b0};
         end
      end
      a_miso = force_one ? 1'b1 : pa_sh[7];
   end

   // Peripheral B: MISO changes one system cycle after each SCK fall.
   logic [7:0] b_miso_byte;
   logic [7:0] pb_sh = 8'h00;
   logic       pb_cs_seen;

   always @(b_cs or negedge b_sck) begin
      if (b_cs !== pb_cs_seen) begin
         pb_cs_seen = b_cs;
         if (b_cs === 1'b0) begin
            pb_sh  = b_miso_byte;
            b_miso = pb_sh[7];
         end
      end else if (b_cs === 1'b0 && b_sck === 1'b0) begin
         pb_sh = {pb_sh[6:0], 1'b0};
         @(posedge clk);
         #1 b_miso = pb_sh[7];
      end
   end

   // Cumulative monitors; tests work on differences from a snapshot.
   int   a_cs_low = 0, a_rises = 0, a_next_sck = 0, b_cs_low = 0;
   logic [7:0] a_rx_log [$];
   logic [7:0] b_rx_log [$];
   logic a_mosi_log [$];
   logic b_mosi_log [$];

   always @(negedge clk) begin
      if (a_cs === 1'b0) a_cs_low++;
      if (a_rx_valid === 1'b1) a_rx_log.push_back(a_rx_byte);
      if (a_ready === 1'b1 && a_cs === 1'b0 && a_sck === 1'b1) a_next_sck++;
      if (b_cs === 1'b0) b_cs_low++;
      if (b_rx_valid === 1'b1) b_rx_log.push_back(b_rx_byte);
   end

   always @(posedge a_sck) begin
      a_rises++;
      a_mosi_log.push_back(a_mosi);
   end

   always @(posedge b_sck) b_mosi_log.push_back(b_mosi);

   function automatic logic [7:0] bits_to_byte(input logic q[$], input int s);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < 8; i++) r = {r[6:0], (s + i < q.size()) ? q[s + i] : 1'bx};
      return r;
   endfunction

   function automatic logic [7:0] rx_at(input int i);
      return (i < a_rx_log.size()) ? a_rx_log[i] : 8'hxx;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_check(input string name, input int n);
      checks++;
      if (n >= 5000) begin
         failures++;
         $display("FAIL %s: waited %0d cycles, required the event within 5000", name, n);
      end
   endtask

   task automatic send_a(input logic [7:0] b, input logic l, input bit drop);
      int n = 0;
      a_byte  = b;
      a_last  = l;
      a_valid = 1'b1;
      while (a_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("send_a_ready", n);
      @(negedge clk);
      if (drop) a_valid = 1'b0;
   endtask

   task automatic finish_a(output int gap);
      int n = 0;
      while (a_cs !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("cs_rise", n);
      gap = 0;
      while (a_ready !== 1'b1 && gap < 100) begin
         gap++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] miso;
      logic [7:0] rx_exp;
      int         cs_low_exp;
      int         gap_exp;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   gap, n, bad, s_cs, s_rx, s_mosi, s_rises, s_next;

      vecs[0] = '{tx: 8'hA5, miso: 8'h3C, rx_exp: 8'h3C, cs_low_exp: 72, gap_exp: 4};
      vecs[1] = '{tx: 8'hFF, miso: 8'h00, rx_exp: 8'h00, cs_low_exp: 72, gap_exp: 4};
      vecs[2] = '{tx: 8'h00, miso: 8'hFF, rx_exp: 8'hFF, cs_low_exp: 72, gap_exp: 4};
      vecs[3] = '{tx: 8'h81, miso: 8'h7E, rx_exp: 8'h7E, cs_low_exp: 72, gap_exp: 4};

      rst_n   = 1'b0;
      a_byte  = 8'h00; a_last = 1'b0; a_valid = 1'b0;
      b_byte  = 8'h00; b_last = 1'b0; b_valid = 1'b0;
      b_miso_byte = 8'h00;
`ifdef SPI_CONTROLLER_LOOPBACK_EN
      a_loop = 1'b0;
      b_loop = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_cs_n", a_cs, 1);
      check("rst_sck", a_sck, 0);
      check("rst_mosi", a_mosi, 0);
      check("rst_ready", a_ready, 0);
      check("rst_rx_valid", a_rx_valid, 0);
      check("rst_rx_byte", a_rx_byte, 8'h00);
      check("rst_busy", a_busy, 0);
      rst_n = 1'b1;
      n = 0;
      while (a_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("rst_gap", n, 4);

      // Single-byte transactions from the vector table.
      for (int i = 0; i < 4; i++) begin
         miso_mem[am_wr] = vecs[i].miso;
         am_wr++;
         s_cs = a_cs_low; s_rx = a_rx_log.size(); s_mosi = a_mosi_log.size(); s_rises = a_rises;
         send_a(vecs[i].tx, 1'b1, 1'b1);
         if (i == 0) check("busy_active", a_busy, 1);
         finish_a(gap);
         check($sformatf("v%0d_mosi", i), bits_to_byte(a_mosi_log, s_mosi), vecs[i].tx);
         check($sformatf("v%0d_rx_count", i), a_rx_log.size() - s_rx, 1);
         check($sformatf("v%0d_rx", i), rx_at(s_rx), vecs[i].rx_exp);
         check($sformatf("v%0d_cs_low", i), a_cs_low - s_cs, vecs[i].cs_low_exp);
         check($sformatf("v%0d_rises", i), a_rises - s_rises, 8);
         check($sformatf("v%0d_gap", i), gap, vecs[i].gap_exp);
      end
      check("busy_idle", a_busy, 0);

      // Three bytes under one CS_N, valid held high throughout.
      miso_mem[am_wr] = 8'h11; miso_mem[am_wr + 1] = 8'h22; miso_mem[am_wr + 2] = 8'h33;
      am_wr += 3;
      s_cs = a_cs_low; s_rx = a_rx_log.size(); s_mosi = a_mosi_log.size();
      s_rises = a_rises; s_next = a_next_sck;
      send_a(8'h01, 1'b0, 1'b0);
      send_a(8'h02, 1'b0, 1'b0);
      send_a(8'h03, 1'b1, 1'b1);
      finish_a(gap);
      check("multi_rises", a_rises - s_rises, 24);
      check("multi_rx_count", a_rx_log.size() - s_rx, 3);
      check("multi_rx0", rx_at(s_rx), 8'h11);
      check("multi_rx1", rx_at(s_rx + 1), 8'h22);
      check("multi_rx2", rx_at(s_rx + 2), 8'h33);
      check("multi_mosi2", bits_to_byte(a_mosi_log, s_mosi + 16), 8'h03);
      check("multi_cs_low", a_cs_low - s_cs, 202);
      check("multi_next_sck", a_next_sck - s_next, 0);

      // Stall in NEXT for 100 cycles.
      miso_mem[am_wr] = 8'h5A; miso_mem[am_wr + 1] = 8'h96;
      am_wr += 2;
      s_rx = a_rx_log.size(); s_mosi = a_mosi_log.size(); s_rises = a_rises;
      send_a(8'hC3, 1'b0, 1'b1);
      n = 0;
      while (!(a_ready === 1'b1 && a_cs === 1'b0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("stall_enter_next", n);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_sck !== 1'b0 || a_cs !== 1'b0 || a_ready !== 1'b1) bad++;
      end
      check("stall_hold", bad, 0);
      send_a(8'h69, 1'b1, 1'b1);
      finish_a(gap);
      check("stall_rises", a_rises - s_rises, 16);
      check("stall_rx0", rx_at(s_rx), 8'h5A);
      check("stall_rx1", rx_at(s_rx + 1), 8'h96);
      check("stall_mosi1", bits_to_byte(a_mosi_log, s_mosi + 8), 8'h69);

      // Reset pulsed during the fifth bit.
      miso_mem[am_wr] = 8'h3C;
      am_wr++;
      s_rx = a_rx_log.size(); s_rises = a_rises;
      send_a(8'hA5, 1'b1, 1'b1);
      n = 0;
      while (a_rises - s_rises < 5 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("abort_fifth_rise", n);
      rst_n = 1'b0;
      #1;
      check("abort_cs_n", a_cs, 1);
      check("abort_sck", a_sck, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (a_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("abort_gap", n, 4);
      check("abort_no_rx", a_rx_log.size() - s_rx, 0);
      miso_mem[am_wr] = 8'hE7;
      am_wr++;
      s_cs = a_cs_low; s_rx = a_rx_log.size(); s_mosi = a_mosi_log.size();
      send_a(8'h96, 1'b1, 1'b1);
      finish_a(gap);
      check("after_abort_mosi", bits_to_byte(a_mosi_log, s_mosi), 8'h96);
      check("after_abort_rx", rx_at(s_rx), 8'hE7);
      check("after_abort_cs_low", a_cs_low - s_cs, 72);

      // Minimum half-period with a late peripheral.
      b_miso_byte = 8'hC3;
      s_cs = b_cs_low; s_rx = b_rx_log.size(); s_mosi = b_mosi_log.size();
      b_byte = 8'h3C; b_last = 1'b1; b_valid = 1'b1;
      n = 0;
      while (b_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("b_ready", n);
      @(negedge clk);
      b_valid = 1'b0;
      check("b_busy", b_busy, 1);
      n = 0;
      while (b_cs !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      bound_check("b_cs_rise", n);
      check("b_rx_count", b_rx_log.size() - s_rx, 1);
      check("b_rx", (s_rx < b_rx_log.size()) ? b_rx_log[s_rx] : 8'hxx, 8'hC3);
      check("b_mosi", bits_to_byte(b_mosi_log, s_mosi), 8'h3C);
      check("b_cs_low", b_cs_low - s_cs, 36);

`ifdef SPI_CONTROLLER_LOOPBACK_EN
      a_loop = 1'b1;
      force_one = 1'b1;
      s_rx = a_rx_log.size();
      send_a(8'h5A, 1'b1, 1'b1);
      finish_a(gap);
      check("loopback_rx", rx_at(s_rx), 8'h5A);
      a_loop = 1'b0;
      force_one = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
